// File: rtl/deck_shuffler.sv
// Card deck shuffler: rebuilds a deck, Fisher-Yates shuffles it with a 6-bit LFSR
// using rejection sampling, then deals one decoded card per accepted request.
module deck_shuffler #(
  parameter int DECK_SIZE  = 52,
  parameter int MAX_SEARCH = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seed,
  input  logic       shuffle_start,
  input  logic       deal_req,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic       deck_ready,
  output logic       deck_empty,
  output logic [5:0] cards_left,
  output logic [2:0] shuf_state
);

  localparam logic [5:0] LAST_IDX   = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL_CNT   = 6'(DECK_SIZE);
  localparam logic [5:0] SEARCH_LIM = 6'(MAX_SEARCH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHUFFLE = 3'd2,
    S_READY   = 3'd3,
    S_EMPTY   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  deck_q [DECK_SIZE];
  logic [5:0]  deck_d [DECK_SIZE];
  logic [5:0]  lfsr_q, lfsr_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  left_q, left_d;
  logic [5:0]  search_q, search_d;
  logic        card_valid_q, card_valid_d;
  logic [3:0]  card_rank_q, card_rank_d;
  logic [1:0]  card_suit_q, card_suit_d;
  logic        deck_ready_q, deck_empty_q;
  logic [5:0]  rnd_s, pick_s;
  logic        swap_s;

  function automatic logic [5:0] lfsr_step(input logic [5:0] l);
    return {l[4:0], l[5] ^ l[4]};
  endfunction

  // Returns {suit, rank} for a card index.
  function automatic logic [5:0] decode_card(input logic [5:0] c);
    logic [5:0] rem;
    logic [1:0] suit;
    if (c >= 6'd39) begin
      suit = 2'd3; rem = c - 6'd39;
    end else if (c >= 6'd26) begin
      suit = 2'd2; rem = c - 6'd26;
    end else if (c >= 6'd13) begin
      suit = 2'd1; rem = c - 6'd13;
    end else begin
      suit = 2'd0; rem = c;
    end
    return {suit, 4'(rem + 6'd1)};
  endfunction

  // Rejection sample; a run of MAX_SEARCH-1 misses forces a self-swap so no step can stall.
  always_comb begin
    rnd_s = lfsr_q - 6'd1;
    if (rnd_s <= idx_q) begin
      pick_s = rnd_s;
    end else begin
      pick_s = idx_q;
    end
    if (state_q == S_SHUFFLE) begin
      swap_s = (rnd_s <= idx_q) || (search_q >= SEARCH_LIM);
    end else begin
      swap_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; shuffle_start wins over everything else.
  always_comb begin
    state_d = state_q;
    if (shuffle_start) begin
      state_d = S_INIT;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_INIT:    state_d = S_SHUFFLE;
        S_SHUFFLE: begin
          if (swap_s && (idx_q == 6'd1)) state_d = S_READY;
          else                           state_d = S_SHUFFLE;
        end
        S_READY: begin
          if (deal_req && (ptr_q == LAST_IDX)) state_d = S_EMPTY;
          else                                 state_d = S_READY;
        end
        S_EMPTY:   state_d = S_EMPTY;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    deck_d       = deck_q;
    lfsr_d       = lfsr_q;
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    left_d       = left_q;
    search_d     = search_q;
    card_valid_d = 1'b0;
    card_rank_d  = card_rank_q;
    card_suit_d  = card_suit_q;
    if (shuffle_start) begin
      if (seed == 6'd0) lfsr_d = 6'd1;
      else              lfsr_d = seed;
    end else begin
      case (state_q)
        S_INIT: begin
          for (int k = 0; k < DECK_SIZE; k++) deck_d[k] = 6'(k);
          idx_d    = LAST_IDX;
          ptr_d    = 6'd0;
          left_d   = 6'd0;
          search_d = 6'd0;
        end
        S_SHUFFLE: begin
          lfsr_d = lfsr_step(lfsr_q);
          if (swap_s) begin
            deck_d[idx_q]  = deck_q[pick_s];
            deck_d[pick_s] = deck_q[idx_q];
            idx_d          = idx_q - 6'd1;
            search_d       = 6'd0;
            if (idx_q == 6'd1) left_d = FULL_CNT;
            else               left_d = left_q;
          end else begin
            search_d = search_q + 6'd1;
          end
        end
        S_READY: begin
          if (deal_req) begin
            card_valid_d               = 1'b1;
            {card_suit_d, card_rank_d} = decode_card(deck_q[ptr_q]);
            ptr_d                      = ptr_q + 6'd1;
            left_d                     = left_q - 6'd1;
          end else begin
            card_valid_d = 1'b0;
          end
        end
        default: card_valid_d = 1'b0;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DECK_SIZE; k++) deck_q[k] <= 6'd0;
      lfsr_q       <= 6'd1;
      idx_q        <= 6'd0;
      ptr_q        <= 6'd0;
      left_q       <= 6'd0;
      search_q     <= 6'd0;
      card_valid_q <= 1'b0;
      card_rank_q  <= 4'd0;
      card_suit_q  <= 2'd0;
      deck_ready_q <= 1'b0;
      deck_empty_q <= 1'b0;
    end else begin
      deck_q       <= deck_d;
      lfsr_q       <= lfsr_d;
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      left_q       <= left_d;
      search_q     <= search_d;
      card_valid_q <= card_valid_d;
      card_rank_q  <= card_rank_d;
      card_suit_q  <= card_suit_d;
      deck_ready_q <= (state_d == S_READY);
      deck_empty_q <= (state_d == S_EMPTY);
    end
  end

  assign card_valid = card_valid_q;
  assign card_rank  = card_rank_q;
  assign card_suit  = card_suit_q;
  assign deck_ready = deck_ready_q;
  assign deck_empty = deck_empty_q;
  assign cards_left = left_q;
  assign shuf_state = state_q;

endmodule

// File: tb/tb_deck_shuffler.sv
// Self-checking bench for deck_shuffler: a reference shuffle model fills a scoreboard
// of expected cards, and a negedge monitor compares every card_valid strobe.
module tb_deck_shuffler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] seed = 6'd0;
  logic       shuffle_start = 1'b0;
  logic       deal_req = 1'b0;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic       deck_ready;
  logic       deck_empty;
  logic [5:0] cards_left;
  logic [2:0] shuf_state;

  deck_shuffler #(.DECK_SIZE(52), .MAX_SEARCH(63)) dut (
    .clk(clk), .rst(rst), .seed(seed), .shuffle_start(shuffle_start),
    .deal_req(deal_req), .card_valid(card_valid), .card_rank(card_rank),
    .card_suit(card_suit), .deck_ready(deck_ready), .deck_empty(deck_empty),
    .cards_left(cards_left), .shuf_state(shuf_state)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         exp_left = 0;
  logic [5:0] sb[$];
  logic [5:0] obs_q[$];
  logic [5:0] exp_deck[52];
  logic [5:0] run_seq[5][52];
  logic [5:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [5:0] card_code(input int c);
    return {2'(c / 13), 4'((c % 13) + 1)};
  endfunction

  task automatic model_shuffle(input logic [5:0] s);
    int d[52];
    logic [5:0] l;
    int i, r, t;
    for (int k = 0; k < 52; k++) d[k] = k;
    l = (s == 6'd0) ? 6'd1 : s;
    i = 51;
    while (i >= 1) begin
      r = int'(l) - 1;
      if (r <= i) begin
        t = d[i]; d[i] = d[r]; d[r] = t;
        i--;
      end
      l = {l[4:0], l[5] ^ l[4]};
    end
    for (int k = 0; k < 52; k++) exp_deck[k] = card_code(d[k]);
  endtask

  // Scoreboard monitor: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (card_valid === 1'b1) begin
      check("strobe_pending", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        check("card", {card_suit, card_rank}, mon_exp);
      end
      obs_q.push_back({card_suit, card_rank});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int c = 0;
    while (deck_ready !== 1'b1 && c < 3215) begin
      step();
      c++;
    end
    check("deck_ready", deck_ready, 1);
    check("cards_left_full", cards_left, 52);
    check("state_ready", shuf_state, 3);
    exp_left = 52;
  endtask

  task automatic start_shuffle(input logic [5:0] s);
    seed = s;
    shuffle_start = 1'b1;
    step();
    shuffle_start = 1'b0;
    check("state_init", shuf_state, 1);
    model_shuffle(s);
    step();
    check("state_shuffle", shuf_state, 2);
    wait_ready();
  endtask

  task automatic deal_n(input int n, input bit pulsed);
    for (int j = 0; j < n; j++) begin
      deal_req = 1'b1;
      sb.push_back(exp_deck[52 - exp_left]);
      step();
      deal_req = 1'b0;
      exp_left--;
      check("cards_left", cards_left, exp_left);
      if (pulsed) step();
    end
    if (!pulsed) step();
  endtask

  task automatic deal_all(input int run, input bit pulsed);
    logic [51:0] seen;
    int idx;
    obs_q.delete();
    deal_n(52, pulsed);
    check("deck_empty", deck_empty, 1);
    check("state_empty", shuf_state, 4);
    check("cards_left_zero", cards_left, 0);
    seen = '0;
    foreach (obs_q[k]) begin
      if (obs_q[k][3:0] >= 4'd1 && obs_q[k][3:0] <= 4'd13) begin
        idx = int'(obs_q[k][5:4]) * 13 + int'(obs_q[k][3:0]) - 1;
        seen[idx] = 1'b1;
      end
    end
    check("distinct_cards", $countones(seen), 52);
    for (int k = 0; k < 52; k++) run_seq[run][k] = (k < obs_q.size()) ? obs_q[k] : 6'h3f;
    deal_req = 1'b1;
    step();
    deal_req = 1'b0;
    check("deal_53_no_strobe", card_valid, 0);
    check("hold_last_card", {card_suit, card_rank}, exp_deck[51]);
    check("still_empty", shuf_state, 4);
  endtask

  function automatic int diff_runs(input int a, input int b);
    int cnt = 0;
    for (int k = 0; k < 52; k++) if (run_seq[a][k] !== run_seq[b][k]) cnt++;
    return cnt;
  endfunction

  initial begin
    #2;
    check("rst_card_valid", card_valid, 0);
    check("rst_rank_suit", {card_suit, card_rank}, 0);
    check("rst_ready_empty", {deck_ready, deck_empty}, 0);
    check("rst_cards_left", cards_left, 0);
    check("rst_state", shuf_state, 0);
    #11 rst = 1'b1;
    step();

    deal_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_no_strobe", card_valid, 0);
    end
    deal_req = 1'b0;
    check("idle_state", shuf_state, 0);
    check("idle_cards_left", cards_left, 0);

    start_shuffle(6'b001010);
    deal_all(0, 1'b0);
    start_shuffle(6'b001010);
    deal_all(1, 1'b1);
    check("same_seed_same_deal", diff_runs(0, 1), 0);
    start_shuffle(6'd0);
    deal_all(2, 1'b0);
    start_shuffle(6'd1);
    deal_all(3, 1'b0);
    check("seed0_eq_seed1", diff_runs(2, 3), 0);
    start_shuffle(6'b001011);
    deal_all(4, 1'b0);
    check("seed11_differs", (diff_runs(0, 4) != 0), 1);

    start_shuffle(6'b001010);
    seed = 6'b001010;
    shuffle_start = 1'b1;
    deal_req = 1'b1;
    step();
    shuffle_start = 1'b0;
    deal_req = 1'b0;
    check("start_overrides_deal", card_valid, 0);
    check("start_to_init", shuf_state, 1);
    step();
    check("init_to_shuffle", shuf_state, 2);
    repeat (5) step();
    check("mid_shuffle_state", shuf_state, 2);
    check("mid_shuffle_left", cards_left, 0);
    seed = 6'b001011;
    shuffle_start = 1'b1;
    step();
    shuffle_start = 1'b0;
    check("restart_init", shuf_state, 1);
    model_shuffle(6'b001011);
    wait_ready();
    deal_n(5, 1'b0);

    start_shuffle(6'd1);
    deal_n(20, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_card_valid", card_valid, 0);
    check("async_rank_suit", {card_suit, card_rank}, 0);
    check("async_ready_empty", {deck_ready, deck_empty}, 0);
    check("async_cards_left", cards_left, 0);
    check("async_state", shuf_state, 0);
    #3 rst = 1'b1;
    step();
    deal_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("post_rst_no_strobe", card_valid, 0);
      check("post_rst_idle", shuf_state, 0);
    end
    deal_req = 1'b0;
    start_shuffle(6'd1);
    deal_n(3, 1'b1);

    step();
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
